uart_rx: RTL and testbench

Serial receiver forming the downstream stage of the UART transmit path: it consumes the `tx` line produced by the UART transmitter, either looped back or across the board link, and recovers parallel words. Frame format, bit timing (`clk_div`) and word length (`bits_per_word`) match the transmitter exactly, so both ends share one register set. The received word is held in an output register with a ready/acknowledge handshake toward the bus-side register block, plus framing-error and overrun flags.

---
 rtl/uart_rx.sv | 133 +++++++++++++
 tb/tb_uart_rx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronized serial input, mid-bit sampling FSM, held
// output word with read-acknowledge handshake, framing-error and overrun flags.
module uart_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [15:0] clk_div,
  input  logic [4:0]  bits_per_word,
  input  logic        rd_en,
  output logic [15:0] data_out,
  output logic        data_ready,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_s_q, rx_prev_q;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] shift_q, shift_d;
  logic [15:0] data_q, data_d;
  logic        ready_q, ready_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;

  logic [3:0]  last_idx;
  logic [15:0] word_mask;
  logic [15:0] half_div;
  logic        fall;
  logic        ack;

  assign last_idx  = bits_per_word[4] ? 4'd15 : bits_per_word[3:0];
  assign word_mask = 16'hFFFF >> (4'd15 - last_idx);
  assign half_div  = {1'b0, clk_div[15:1]};
  assign fall      = rx_prev_q & ~rx_s_q;
  assign ack       = rd_en & ready_q;

  // Synchronizer resets high so leaving reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= 16'd1;
      idx_q     <= 4'd0;
      shift_q   <= 16'd0;
      data_q    <= 16'd0;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  // Compares use >= so a mid-frame clk_div change cannot strand the FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = ack ? 1'b0 : ready_q;
    ferr_d  = ferr_q;
    ovr_d   = ack ? 1'b0 : ovr_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 16'd1;
        if (fall) state_d = S_START;
      end
      S_START: begin
        if (cnt_q >= half_div) begin
          cnt_d = 16'd1;
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = 4'd0;
          end
        end
      end
      S_DATA: begin
        if (cnt_q >= clk_div) begin
          cnt_d          = 16'd1;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == last_idx) state_d = S_STOP;
          else                   idx_d   = idx_q + 4'd1;
        end
      end
      S_STOP: begin
        if (cnt_q >= clk_div) begin
          cnt_d   = 16'd1;
          state_d = S_IDLE;
          data_d  = shift_q & word_mask;
          ready_d = 1'b1;
          ferr_d  = ~rx_s_q;
          // A same-cycle acknowledge consumes the old word, so no overrun.
          ovr_d   = ready_q & ~rd_en;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd1;
      end
    endcase
  end

  assign data_out   = data_q;
  assign data_ready = ready_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit-by-bit on the falling clock
// edge and outputs are compared on falling edges against hand-computed values.
module tb_uart_rx;

  logic        clk;
  logic        rst;
  logic        rx;
  logic [15:0] clk_div;
  logic [4:0]  bits_per_word;
  logic        rd_en;
  logic [15:0] data_out;
  logic        data_ready;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  uart_rx dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .clk_div       (clk_div),
    .bits_per_word (bits_per_word),
    .rd_en         (rd_en),
    .data_out      (data_out),
    .data_ready    (data_ready),
    .frame_err     (frame_err),
    .overrun       (overrun),
    .busy          (busy)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One frame, one cycle per loop pass; slot 0 start, 1..nbits data, last stop.
  // rd_en is pulsed for the negedge index ack_at (negative: no pulse).
  task automatic send_frame(input logic [15:0] data, input int nbits, input int div,
                            input logic stop_bit, input int ack_at);
    int total;
    int slot;
    total = (nbits + 2) * div;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      slot = c / div;
      if (slot == 0)          rx = 1'b0;
      else if (slot <= nbits) rx = data[slot-1];
      else                    rx = stop_bit;
      rd_en = (c == ack_at);
    end
  endtask

  task automatic ack_word();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst           = 1'b1;
    rx            = 1'b1;
    rd_en         = 1'b0;
    clk_div       = 16'd16;
    bits_per_word = 5'd7;
    idle_cycles(3);
    check("rst_data_out",   data_out,          16'h0000);
    check("rst_data_ready", {15'd0, data_ready}, 16'd0);
    check("rst_frame_err",  {15'd0, frame_err},  16'd0);
    check("rst_overrun",    {15'd0, overrun},    16'd0);
    check("rst_busy",       {15'd0, busy},       16'd0);
    rst = 1'b0;
    idle_cycles(4);

    // single frame 0xA5
    send_frame(16'h00A5, 8, 16, 1'b1, -1);
    check("single_data",  data_out,            16'h00A5);
    check("single_ready", {15'd0, data_ready}, 16'd1);
    check("single_ferr",  {15'd0, frame_err},  16'd0);
    check("single_ovr",   {15'd0, overrun},    16'd0);
    check("single_busy",  {15'd0, busy},       16'd0);
    ack_word();
    check("single_ack_ready", {15'd0, data_ready}, 16'd0);
    idle_cycles(4);

    // back-to-back 16-bit frames; the first word is acknowledged during frame two
    clk_div       = 16'd8;
    bits_per_word = 5'd15;
    send_frame(16'hBEEF, 16, 8, 1'b1, -1);
    check("loop_word0",  data_out,            16'hBEEF);
    check("loop_ready0", {15'd0, data_ready}, 16'd1);
    send_frame(16'h0001, 16, 8, 1'b1, 2);
    check("loop_word1",  data_out,            16'h0001);
    check("loop_ready1", {15'd0, data_ready}, 16'd1);
    check("loop_ovr",    {15'd0, overrun},    16'd0);
    ack_word();
    check("loop_ack_ready", {15'd0, data_ready}, 16'd0);
    idle_cycles(4);

    // bits_per_word above 15 clamps to 16 data bits
    bits_per_word = 5'd31;
    send_frame(16'h1234, 16, 8, 1'b1, -1);
    check("clamp_word", data_out, 16'h1234);
    ack_word();
    // 4-bit word: stale upper shift-register bits must read as zero
    bits_per_word = 5'd3;
    send_frame(16'h000A, 4, 8, 1'b1, -1);
    check("short_word", data_out, 16'h000A);
    ack_word();
    idle_cycles(4);

    // 4-cycle glitch is rejected at the start-bit check
    clk_div       = 16'd16;
    bits_per_word = 5'd7;
    @(negedge clk);
    rx = 1'b0;
    idle_cycles(4);
    check("glitch_busy_hi", {15'd0, busy}, 16'd1);
    rx = 1'b1;
    idle_cycles(20);
    check("glitch_busy_lo", {15'd0, busy},       16'd0);
    check("glitch_ready",   {15'd0, data_ready}, 16'd0);

    // framing error, then a good frame
    send_frame(16'h003C, 8, 16, 1'b0, -1);
    check("ferr_data", data_out,           16'h003C);
    check("ferr_flag", {15'd0, frame_err}, 16'd1);
    @(negedge clk);
    rx = 1'b1;
    idle_cycles(6);
    check("ferr_break_ready", {15'd0, busy}, 16'd0);
    ack_word();
    send_frame(16'h0055, 8, 16, 1'b1, -1);
    check("ferr_good_data", data_out,           16'h0055);
    check("ferr_good_flag", {15'd0, frame_err}, 16'd0);
    ack_word();
    idle_cycles(4);

    // overrun: two words, no acknowledge
    send_frame(16'h0011, 8, 16, 1'b1, -1);
    check("ovr_first_flag", {15'd0, overrun}, 16'd0);
    send_frame(16'h0022, 8, 16, 1'b1, -1);
    check("ovr_data",  data_out,            16'h0022);
    check("ovr_flag",  {15'd0, overrun},    16'd1);
    check("ovr_ready", {15'd0, data_ready}, 16'd1);
    ack_word();
    check("ovr_ack_flag",  {15'd0, overrun},    16'd0);
    check("ovr_ack_ready", {15'd0, data_ready}, 16'd0);
    idle_cycles(4);

    // acknowledge on the completion edge: edge detect 3 + half 8 + 9*16 = 155,
    // so rd_en is raised at negedge 154 of the frame
    send_frame(16'h0011, 8, 16, 1'b1, -1);
    send_frame(16'h0022, 8, 16, 1'b1, 154);
    check("sim_data",  data_out,            16'h0022);
    check("sim_ready", {15'd0, data_ready}, 16'd1);
    check("sim_ovr",   {15'd0, overrun},    16'd0);
    idle_cycles(4);

    // reset during data bit 3 of 0xFF (slot [64,80), reset at 72)
    @(negedge clk);
    rx = 1'b0;
    idle_cycles(16);
    rx = 1'b1;
    idle_cycles(56);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_data",  data_out,            16'h0000);
    check("mid_rst_ready", {15'd0, data_ready}, 16'd0);
    check("mid_rst_ferr",  {15'd0, frame_err},  16'd0);
    check("mid_rst_ovr",   {15'd0, overrun},    16'd0);
    check("mid_rst_busy",  {15'd0, busy},       16'd0);
    idle_cycles(200);
    check("mid_rst_noword", {15'd0, data_ready}, 16'd0);
    send_frame(16'h005A, 8, 16, 1'b1, -1);
    check("post_rst_data",  data_out,            16'h005A);
    check("post_rst_ready", {15'd0, data_ready}, 16'd1);
    check("post_rst_ferr",  {15'd0, frame_err},  16'd0);
    check("post_rst_ovr",   {15'd0, overrun},    16'd0);
    ack_word();
    idle_cycles(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
